// File: rtl/updown_counter_gen.sv
// updown_counter_gen: up/down counter with step, load, ovf/unf pulses and a saturating event counter.
// Optional build macro UPDOWN_COUNTER_GEN_SAT_EN: saturate cnt at 0 / 2^WIDTH-1 instead of wrapping.

module updown_counter_gen_chk (
    input logic clk,
    input logic reset_n,
    input logic ovf,
    input logic unf
);
    a_no_dual_pulse: assert property (@(posedge clk) disable iff (!reset_n) !(ovf && unf))
        else $error("updown_counter_gen: ovf and unf asserted together");
endmodule

module updown_counter_gen #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int EVT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              evt_clr,
    output logic [WIDTH-1:0]  cnt,
    output logic              ovf,
    output logic              unf,
    output logic [EVT_W-1:0]  evt_cnt
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_MIN = {EVT_W{1'b0}};
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1'b1);

    logic [WIDTH-1:0] cnt_r;
    logic             ovf_r;
    logic             unf_r;
    logic [EVT_W-1:0] evt_cnt_r;

    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;
    logic [EVT_W-1:0] evt_nxt_s;

    // Widen step and form both candidate results with a carry/borrow bit.
    always_comb begin
        step_ext_s               = {(WIDTH+1){1'b0}};
        step_ext_s[STEP_W-1:0]   = step;
        sum_s                    = {1'b0, cnt_r} + step_ext_s;
        diff_s                   = {1'b0, cnt_r} - step_ext_s;
    end

    // Next counter value and pulse flags; up and down together cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = 1'b0;
        unf_nxt_s = 1'b0;
        if (load) begin
            cnt_nxt_s = load_val;
        end else begin
            case ({up, down})
                2'b10: begin
                    ovf_nxt_s = sum_s[WIDTH];
`ifdef UPDOWN_COUNTER_GEN_SAT_EN
                    cnt_nxt_s = sum_s[WIDTH] ? CNT_MAX : sum_s[WIDTH-1:0];
`else
                    cnt_nxt_s = sum_s[WIDTH-1:0];
`endif
                end
                2'b01: begin
                    unf_nxt_s = diff_s[WIDTH];
`ifdef UPDOWN_COUNTER_GEN_SAT_EN
                    cnt_nxt_s = diff_s[WIDTH] ? CNT_MIN : diff_s[WIDTH-1:0];
`else
                    cnt_nxt_s = diff_s[WIDTH-1:0];
`endif
                end
                default: begin
                    cnt_nxt_s = cnt_r;
                end
            endcase
        end
    end

    // Event counter follows the registered pulse; clear wins over a coincident event.
    always_comb begin
        if (evt_clr) begin
            evt_nxt_s = EVT_MIN;
        end else if ((ovf_r || unf_r) && (evt_cnt_r != EVT_MAX)) begin
            evt_nxt_s = evt_cnt_r + EVT_ONE;
        end else begin
            evt_nxt_s = evt_cnt_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r     <= CNT_MIN;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            evt_cnt_r <= EVT_MIN;
        end else begin
            cnt_r     <= cnt_nxt_s;
            ovf_r     <= ovf_nxt_s;
            unf_r     <= unf_nxt_s;
            evt_cnt_r <= evt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign ovf     = ovf_r;
    assign unf     = unf_r;
    assign evt_cnt = evt_cnt_r;

    updown_counter_gen_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .ovf     (ovf_r),
        .unf     (unf_r)
    );

endmodule
